// File: rtl/bist_misr_checker_pkg.sv
// Shared types and default constants for the BIST output-response analyser.
package bist_misr_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int         DEF_WIDTH    = 8;
    localparam int         DEF_PATTERNS = 255;
    localparam logic [7:0] DEF_POLY     = 8'h1D;
    localparam logic [7:0] DEF_SEED     = 8'h00;

endpackage

// File: rtl/bist_misr_checker_misr.sv
// Galois-form multiple-input signature register: seed load, enable-gated compaction of i_data.
module bist_misr_checker_misr
    import bist_misr_checker_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_signature
);

    logic [WIDTH-1:0] r_sig;
    logic [WIDTH-1:0] w_feedback;

    // The bit shifted out of the top folds the polynomial back into the register.
    assign w_feedback = r_sig[WIDTH-1] ? POLY : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= SEED;
        end else if (i_load) begin
            r_sig <= SEED;
        end else if (i_enable) begin
            r_sig <= {r_sig[WIDTH-2:0], 1'b0} ^ w_feedback ^ i_data;
        end
    end

    assign o_signature = r_sig;

endmodule

// File: rtl/bist_misr_checker.sv
// BIST response checker: compacts PATTERNS valid responses into a MISR signature,
// compares against a golden value and reports done/pass to the test controller.
module bist_misr_checker
    import bist_misr_checker_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter int               PATTERNS = DEF_PATTERNS,
    parameter logic [WIDTH-1:0] POLY     = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_testmode,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_z_in,
    input  logic             i_z_valid,
    input  logic [WIDTH-1:0] i_golden,
    output logic [WIDTH-1:0] o_signature,
    output logic [7:0]       o_count,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass
);

    // An 8-bit pattern counter must never wrap within a run.
    generate
        if (PATTERNS < 1 || PATTERNS > 255) begin : g_badPatterns
            $error("bist_misr_checker: PATTERNS must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] LAST_COUNT = 8'(PATTERNS - 1);

    state_t           r_state;
    state_t           w_nextState;
    logic [7:0]       r_count;
    logic             r_pass;
    logic             w_start;
    logic             w_load;
    logic             w_enable;
    logic             w_abort;
    logic [WIDTH-1:0] w_signature;

    assign w_start = i_start & i_testmode;

    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_enable    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start) begin
                    w_nextState = ST_COMPACT;
                    w_load      = 1'b1;
                end
            end
            ST_COMPACT: begin
                if (!i_testmode) begin
                    w_nextState = ST_IDLE;
                    w_abort     = 1'b1;
                end else if (i_z_valid) begin
                    w_enable = 1'b1;
                    if (r_count == LAST_COUNT) begin
                        w_nextState = ST_COMPARE;
                    end
                end
            end
            ST_COMPARE: begin
                if (!i_testmode) begin
                    w_nextState = ST_IDLE;
                    w_abort     = 1'b1;
                end else begin
                    w_nextState = ST_DONE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (w_load) begin
            r_count <= 8'd0;
        end else if (w_enable) begin
            r_count <= r_count + 8'd1;
        end
    end

    // The result is captured only on a COMPARE cycle that is not being aborted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass <= 1'b0;
        end else if (w_load || w_abort) begin
            r_pass <= 1'b0;
        end else if (r_state == ST_COMPARE) begin
            r_pass <= (w_signature == i_golden);
        end
    end

    bist_misr_checker_misr #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_enable    (w_enable),
        .i_data      (i_z_in),
        .o_signature (w_signature)
    );

    assign o_signature = w_signature;
    assign o_count     = r_count;
    assign o_busy      = (r_state == ST_COMPACT) || (r_state == ST_COMPARE);
    assign o_done      = (r_state == ST_DONE);
    assign o_pass      = r_pass;

endmodule

// File: tb/tb_bist_misr_checker.sv
// Self-checking bench: directed vector table on small PATTERNS instances plus
// randomized full-length runs checked against a polynomial-arithmetic signature model.
module tb_bist_misr_checker;
    import bist_misr_checker_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       testmode;
    logic       start;
    logic       zValid;
    logic [7:0] zIn;
    logic [7:0] golden;

    logic [7:0] sig  [3];
    logic [7:0] cnt  [3];
    logic       busy [3];
    logic       done [3];
    logic       pass [3];

    int assertCount = 0;
    int failCount   = 0;

    logic [7:0] model;
    logic [7:0] firstSig;
    logic [7:0] runData[$];

    typedef struct packed {
        logic [1:0]      dutSel;
        logic [7:0]      nSamples;
        logic            gap;
        logic [1:0][7:0] data;
        logic [7:0]      golden;
        logic [7:0]      expSig;
        logic            expPass;
    } vec_t;

    vec_t vecs[3];

    always #5 clk = ~clk;

    bist_misr_checker #(.PATTERNS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_testmode(testmode), .i_start(start),
        .i_z_in(zIn), .i_z_valid(zValid), .i_golden(golden),
        .o_signature(sig[0]), .o_count(cnt[0]), .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0])
    );

    bist_misr_checker #(.PATTERNS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_testmode(testmode), .i_start(start),
        .i_z_in(zIn), .i_z_valid(zValid), .i_golden(golden),
        .o_signature(sig[1]), .o_count(cnt[1]), .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1])
    );

    bist_misr_checker u_dutDef (
        .clk(clk), .rst_n(rst_n), .i_testmode(testmode), .i_start(start),
        .i_z_in(zIn), .i_z_valid(zValid), .i_golden(golden),
        .o_signature(sig[2]), .o_count(cnt[2]), .o_busy(busy[2]), .o_done(done[2]), .o_pass(pass[2])
    );

    // Signature as a GF(2) polynomial: multiply by x, reduce modulo x^8+x^4+x^3+x^2+1, add the response.
    function automatic logic [7:0] refStep(input logic [7:0] s, input logic [7:0] d);
        int unsigned t;
        t = 32'(s) * 2;
        if (t >= 256) t = t ^ 32'h11D;
        return t[7:0] ^ d;
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic checkFlag(input string name, input logic act, input logic exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Abort everything to IDLE, start the selected run, feed its samples, then check COMPARE and DONE.
    task automatic applyStimulus(input vec_t v);
        int s;
        s = int'(v.dutSel);
        testmode = 1'b0;
        zValid   = 1'b0;
        cycle();
        testmode = 1'b1;
        golden   = v.golden;
        start    = 1'b1;
        cycle();
        start = 1'b0;
        checkOutput("vec start count", cnt[s], 8'd0);
        checkOutput("vec start seed", sig[s], DEF_SEED);
        for (int i = 0; i < int'(v.nSamples); i++) begin
            if (v.gap && i == 1) begin
                zValid = 1'b0;
                zIn    = 8'hFF;
                cycle();
            end
            zIn    = v.data[i];
            zValid = 1'b1;
            cycle();
        end
        zValid = 1'b0;
        checkFlag("vec compare busy", busy[s], 1'b1);
        checkFlag("vec compare not done", done[s], 1'b0);
        cycle();
        checkFlag("vec done", done[s], 1'b1);
        checkFlag("vec done not busy", busy[s], 1'b0);
        checkOutput("vec signature", sig[s], v.expSig);
        checkOutput("vec count", cnt[s], v.nSamples);
        checkFlag("vec pass", pass[s], v.expPass);
    endtask

    // Feed n valid samples to all instances with random idle gaps, advancing the model.
    task automatic compactRandom(input int n, input int startPulseAt, input bit replay);
        logic [7:0] d;
        int gaps;
        for (int i = 0; i < n; i++) begin
            gaps = int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) begin
                zValid = 1'b0;
                zIn    = 8'($urandom);
                cycle();
            end
            if (replay) d = runData[i];
            else begin
                d = 8'($urandom);
                runData.push_back(d);
            end
            zIn    = d;
            zValid = 1'b1;
            start  = (i == startPulseAt);
            cycle();
            start = 1'b0;
            model = refStep(model, d);
        end
        zValid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        vecs[0] = '{dutSel: 2'd0, nSamples: 8'd1, gap: 1'b0, data: {8'h00, 8'h5A},
                    golden: 8'h5A, expSig: 8'h5A, expPass: 1'b1};
        vecs[1] = '{dutSel: 2'd1, nSamples: 8'd2, gap: 1'b0, data: {8'h00, 8'h80},
                    golden: 8'h1D, expSig: 8'h1D, expPass: 1'b1};
        vecs[2] = '{dutSel: 2'd1, nSamples: 8'd2, gap: 1'b1, data: {8'h01, 8'h01},
                    golden: 8'h04, expSig: 8'h03, expPass: 1'b0};

        rst_n    = 1'b0;
        testmode = 1'b0;
        start    = 1'b0;
        zValid   = 1'b0;
        zIn      = 8'h00;
        golden   = 8'h00;
        @(negedge clk);
        checkOutput("reset signature", sig[2], DEF_SEED);
        checkOutput("reset count", cnt[2], 8'd0);
        checkFlag("reset busy", busy[2], 1'b0);
        checkFlag("reset done", done[2], 1'b0);
        checkFlag("reset pass", pass[2], 1'b0);
        rst_n = 1'b1;
        cycle();

        for (int v = 0; v < 3; v++) applyStimulus(vecs[v]);

        // Abort after 100 samples: IDLE next cycle, signature and count retained.
        testmode = 1'b0;
        cycle();
        testmode = 1'b1;
        start    = 1'b1;
        cycle();
        start = 1'b0;
        model = DEF_SEED;
        compactRandom(100, -1, 1'b0);
        checkOutput("pre-abort count", cnt[2], 8'd100);
        checkOutput("pre-abort signature", sig[2], model);
        testmode = 1'b0;
        cycle();
        checkFlag("abort busy", busy[2], 1'b0);
        checkFlag("abort done", done[2], 1'b0);
        checkFlag("abort pass", pass[2], 1'b0);
        checkOutput("abort count held", cnt[2], 8'd100);
        checkOutput("abort signature held", sig[2], model);
        start = 1'b1;
        cycle();
        start = 1'b0;
        checkFlag("start without testmode ignored", busy[2], 1'b0);

        // Asynchronous reset between clock edges in the middle of a run.
        testmode = 1'b1;
        start    = 1'b1;
        cycle();
        start = 1'b0;
        model = DEF_SEED;
        runData.delete();
        compactRandom(20, -1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset signature", sig[2], DEF_SEED);
        checkOutput("async reset count", cnt[2], 8'd0);
        checkFlag("async reset busy", busy[2], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Full-length run with a start pulse mid-compaction that must not restart it.
        start = 1'b1;
        cycle();
        start = 1'b0;
        model = DEF_SEED;
        runData.delete();
        compactRandom(255, 50, 1'b0);
        golden = model;
        waited = 0;
        cycle();
        while (!done[2] && waited < 8) begin
            cycle();
            waited++;
        end
        checkOutput("done latency extra cycles", 8'(waited), 8'd0);
        checkOutput("full run signature", sig[2], model);
        checkOutput("full run count", cnt[2], 8'hFF);
        checkFlag("full run pass", pass[2], 1'b1);
        firstSig = sig[2];

        zIn    = 8'hA5;
        zValid = 1'b1;
        cycle();
        zValid = 1'b0;
        checkOutput("z_valid in DONE ignored", sig[2], model);
        checkFlag("done held", done[2], 1'b1);
        testmode = 1'b0;
        cycle();
        checkFlag("DONE kept without testmode", done[2], 1'b1);
        checkFlag("pass kept without testmode", pass[2], 1'b1);
        testmode = 1'b1;

        // Second run from DONE replays the same responses.
        start = 1'b1;
        cycle();
        start = 1'b0;
        checkFlag("restart clears pass", pass[2], 1'b0);
        checkFlag("restart clears done", done[2], 1'b0);
        checkOutput("restart count", cnt[2], 8'd0);
        checkOutput("restart seed", sig[2], DEF_SEED);
        model = DEF_SEED;
        compactRandom(255, -1, 1'b1);
        golden = model;
        cycle();
        checkFlag("second run done", done[2], 1'b1);
        checkOutput("second run identical signature", sig[2], firstSig);
        checkFlag("second run pass", pass[2], 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
